// File: rtl/jtag_host_seq.sv
// JTAG host sequencer: turns RESET/SHIFT_IR/SHIFT_DR/RUN_IDLE commands into TMS/TDI and captures TDO.
// Latency from IDLE DR n+5, IR n+6, RESET 6, RUN n (+1 from TLR); cmd_ready low while a command runs.
module jtag_host_seq #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              TCLK,
  input  logic              TRSTN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              TDO,
  output logic              TMS,
  output logic              TDI,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [3:0]        tap_state
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,  IDLE   = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } tap_e;

  typedef enum logic [2:0] {H_WAIT, H_PRE, H_SHIFT, H_POST, H_RST, H_RUN} host_e;

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DATA_W);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W:0]   CNT_ONE  = (LEN_W+1)'(1);
  localparam logic [LEN_W:0]   CNT_FIVE = (LEN_W+1)'(5);
  localparam logic [LEN_W:0]   CNT_SIX  = (LEN_W+1)'(6);

  tap_e              tap_q;
  tap_e              tap_nx;
  host_e             st;
  logic [4:0]        pre_pat;
  logic [4:0]        pat;
  logic [2:0]        pre_left;
  logic [2:0]        pat_len;
  logic [LEN_W:0]    cnt;
  logic [LEN_W:0]    run_n;
  logic [LEN_W-1:0]  nbits;
  logic [LEN_W-1:0]  shift_n;
  logic [DATA_W-1:0] sh_dat;
  logic [DATA_W-1:0] cap;
  logic              from_tlr;
  logic              accept;
  logic              fin;

  assign tap_state = tap_q;

  // Shadow of the target TAP, stepped by the TMS value the target sees at this edge.
  always_comb begin
    tap_nx = tap_q;
    case (tap_q)
      TLR:    tap_nx = TMS ? TLR    : IDLE;
      IDLE:   tap_nx = TMS ? SEL_DR : IDLE;
      SEL_DR: tap_nx = TMS ? SEL_IR : CAP_DR;
      CAP_DR: tap_nx = TMS ? EX1_DR : SH_DR;
      SH_DR:  tap_nx = TMS ? EX1_DR : SH_DR;
      EX1_DR: tap_nx = TMS ? UPD_DR : PAU_DR;
      PAU_DR: tap_nx = TMS ? EX2_DR : PAU_DR;
      EX2_DR: tap_nx = TMS ? UPD_DR : SH_DR;
      UPD_DR: tap_nx = TMS ? SEL_DR : IDLE;
      SEL_IR: tap_nx = TMS ? TLR    : CAP_IR;
      CAP_IR: tap_nx = TMS ? EX1_IR : SH_IR;
      SH_IR:  tap_nx = TMS ? EX1_IR : SH_IR;
      EX1_IR: tap_nx = TMS ? UPD_IR : PAU_IR;
      PAU_IR: tap_nx = TMS ? EX2_IR : PAU_IR;
      EX2_IR: tap_nx = TMS ? UPD_IR : SH_IR;
      UPD_IR: tap_nx = TMS ? SEL_DR : IDLE;
      default: tap_nx = TLR;
    endcase
  end

  always_comb begin
    from_tlr = (tap_q == TLR);
    accept   = cmd_valid && cmd_ready;
    shift_n  = (cmd_len == '0 || cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    run_n    = (cmd_len == '0) ? CNT_ONE : {1'b0, cmd_len};
    run_n    = run_n + {{LEN_W{1'b0}}, from_tlr};
    // Entry path to Shift-xR, LSB emitted first; a leading 0 leaves TLR first.
    pat      = (cmd_op == 2'd1) ? 5'b00011 : 5'b00001;
    pat_len  = (cmd_op == 2'd1) ? 3'd4 : 3'd3;
    if (from_tlr) begin
      pat     = {pat[3:0], 1'b0};
      pat_len = pat_len + 3'd1;
    end
    fin = ((st == H_POST) && (cnt != '0)) ||
          ((st == H_RST)  && (cnt == CNT_SIX)) ||
          ((st == H_RUN)  && (cnt == CNT_ONE));
  end

  always_ff @(posedge TCLK or negedge TRSTN) begin
    if (!TRSTN) begin
      tap_q     <= TLR;
      st        <= H_WAIT;
      TMS       <= 1'b1;
      TDI       <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      pre_pat   <= '0;
      pre_left  <= '0;
      cnt       <= '0;
      nbits     <= '0;
      sh_dat    <= '0;
      cap       <= '0;
    end else begin
      tap_q     <= tap_nx;
      rsp_valid <= 1'b0;
      if (st == H_SHIFT && (tap_q == SH_DR || tap_q == SH_IR))
        cap <= {TDO, cap[DATA_W-1:1]};

      if (fin) begin
        st        <= H_WAIT;
        cmd_ready <= 1'b1;
        rsp_valid <= 1'b1;
        TMS       <= 1'b0;
        TDI       <= 1'b0;
        // Captured bits sit at the top of cap; align them to bit 0.
        rsp_data  <= (st == H_POST) ? (cap >> (LEN_MAX - nbits)) : '0;
      end else begin
        case (st)
          H_WAIT: begin
            TDI <= 1'b0;
            if (accept) begin
              cmd_ready <= 1'b0;
              cap       <= '0;
              case (cmd_op)
                2'd0: begin
                  TMS <= 1'b1;
                  cnt <= CNT_ONE;
                  st  <= H_RST;
                end
                2'd3: begin
                  TMS <= 1'b0;
                  cnt <= run_n;
                  st  <= H_RUN;
                end
                default: begin
                  TMS      <= pat[0];
                  pre_pat  <= pat >> 1;
                  pre_left <= pat_len - 3'd1;
                  nbits    <= shift_n;
                  sh_dat   <= cmd_data;
                  st       <= H_PRE;
                end
              endcase
            end else begin
              TMS <= (tap_nx == TLR);
            end
          end
          H_PRE: begin
            if (pre_left != '0) begin
              TMS      <= pre_pat[0];
              pre_pat  <= pre_pat >> 1;
              pre_left <= pre_left - 3'd1;
            end else begin
              TMS    <= (nbits == LEN_ONE);
              TDI    <= sh_dat[0];
              sh_dat <= sh_dat >> 1;
              cnt    <= CNT_ONE;
              st     <= H_SHIFT;
            end
          end
          H_SHIFT: begin
            if (cnt < {1'b0, nbits}) begin
              TMS    <= (cnt == {1'b0, nbits} - CNT_ONE);
              TDI    <= sh_dat[0];
              sh_dat <= sh_dat >> 1;
              cnt    <= cnt + CNT_ONE;
            end else begin
              TMS <= 1'b1;
              TDI <= 1'b0;
              cnt <= '0;
              st  <= H_POST;
            end
          end
          H_POST: begin
            TMS <= 1'b0;
            cnt <= CNT_ONE;
          end
          H_RST: begin
            TMS <= (cnt != CNT_FIVE);
            cnt <= cnt + CNT_ONE;
          end
          H_RUN: begin
            TMS <= 1'b0;
            cnt <= cnt - CNT_ONE;
          end
          default: st <= H_WAIT;
        endcase
      end
    end
  end

endmodule

// File: doc/jtag_host_seq.md
Name: jtag_host_seq

Overview:
- JTAG host-side sequencer: the driving end of our TAP controller.
- Accepts high-level commands (TAP reset, IR shift, DR shift, idle run) on a valid/ready interface.
- Generates cycle-accurate TMS/TDI on TCLK, samples TDO during shift cycles, and returns captured data.
- Keeps a shadow copy of the target TAP state using the same 16-state encoding as the TAP FSM, so benches can compare the two directly.

Parameters:
- DATA_W, 32, maximum shift length and width of cmd_data/rsp_data.
- LEN_W, 6, width of cmd_len; must satisfy 2^LEN_W > DATA_W.

Ports:
- TCLK  in  1  JTAG clock; all logic on posedge.
- TRSTN  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  host can accept a command.
- cmd_op  in  2  0=RESET, 1=SHIFT_IR, 2=SHIFT_DR, 3=RUN_IDLE.
- cmd_len  in  LEN_W  shift bit count, or idle cycle count for RUN_IDLE.
- cmd_data  in  DATA_W  TDI bits; bit 0 shifted first.
- TDO  in  1  serial data from target.
- TMS  out  1  registered mode select to target.
- TDI  out  1  registered serial data to target.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  DATA_W  captured TDO bits; bit i = i-th sampled bit; unused upper bits 0.
- tap_state  out  4  shadow TAP state (0 TLR, 1 IDLE, 2 SelectDR, 3 CapDR, 4 ShiftDR, 5 Exit1DR, 6 PauseDR, 7 Exit2DR, 8 UpdDR, 9 SelectIR, 10 CapIR, 11 ShiftIR, 12 Exit1IR, 13 PauseIR, 14 Exit2IR, 15 UpdIR).

Behaviour:
- Reset (TRSTN low, async):
  - tap_state=TLR, TMS=1, TDI=0, cmd_ready=1, rsp_valid=0, rsp_data=0.
  - Shift/count registers cleared.
  - Reset mid-command aborts the command with no rsp_valid.
- Clocking and shadow state:
  - TMS/TDI change only after posedge TCLK; the target samples them at the next posedge.
  - tap_state advances every posedge by the TAP transition table applied to the current TMS, so it always equals the target TAP state.
- Host FSM: WAIT, PRE, SHIFT, POST, RST, RUN.
- WAIT:
  - cmd_ready=1, TDI=0.
  - TMS=1 if tap_state=TLR (stay TLR), else TMS=0 (stay IDLE).
  - Accept on posedge with cmd_valid&&cmd_ready.
  - cmd_len=0 is treated as DATA_W for shifts and as 1 for RUN_IDLE.
  - cmd_len>DATA_W is clamped to DATA_W.
- PRE:
  - If tap_state=TLR, emit one TMS=0 first (to IDLE).
  - Then emit TMS 1,0,0 for DR, or 1,1,0,0 for IR, ending in Shift-xR.
- SHIFT:
  - TDI = cmd_data bit k for k=0..n-1.
  - TMS=0 for bits 0..n-2 and TMS=1 on bit n-1 (exits to Exit1).
  - TDO sampled at each posedge where tap_state is Shift-xR, stored into rsp_data bit k.
- POST: emit TMS 1 (Update), then 0 (IDLE).
- RST: emit TMS=1 for 5 cycles, then TMS=0 once; ends in IDLE regardless of start state.
- RUN: emit TMS=0 for n cycles in IDLE (after the TLR→IDLE step if needed).
- Latency, counted in posedges after acceptance, from IDLE:
  - DR: n+5.
  - IR: n+6.
  - RESET: 6.
  - RUN_IDLE: n.
  - Add 1 if starting from TLR (except RESET).
- Completion:
  - On the posedge where tap_state returns to IDLE, return to WAIT; rsp_valid=1 for exactly one cycle, cmd_ready=1.
  - rsp_data holds its value until the next completion.
  - Back-to-back: a command presented during the rsp_valid cycle is accepted at that edge.
- cmd_ready=0 whenever not in WAIT; cmd inputs are ignored while busy.
- TDI=0 outside SHIFT.

Test Plan:
- TRSTN pulse mid-cycle -> tap_state=0, TMS=1, cmd_ready=1, rsp_valid=0 immediately, without a TCLK edge.
- After reset, RESET cmd -> TMS seq 1,1,1,1,1,0; tap_state=1 after 6 edges; rsp_valid one pulse; bench TAP FSM agrees every cycle.
- From IDLE, SHIFT_DR len=8 data=0xA5, bench TDO shift reg preloaded 0x3C LSB-first:
  - TMS=1,0,0,0,0,0,0,0,0,0,1,1,0.
  - TDI bits 1,0,1,0,0,1,0,1.
  - rsp_data=0x0000003C after 13 edges.
- From TLR, SHIFT_IR len=4 data=0x9 -> extra leading TMS=0; total 11 edges; TAP passes states 1,2,9,10,11,11,11,11,12,15,1; target IR receives 0x9.
- RUN_IDLE len=3 immediately followed by SHIFT_DR len=0 (held valid) -> second command accepted in the rsp_valid cycle; shift runs 32 bits; rsp_valid pulses twice, 3 and 37 edges apart.
- TRSTN asserted during SHIFT bit 5 of a 16-bit DR -> no rsp_valid; after release tap_state=TLR; next SHIFT_DR completes correctly with the +1 TLR cycle.
